// File: rtl/arch_reg_commit.sv
// Commit stage: retires in-order ROB entries into the architectural register file.
// Ports: ret_* retire slots in, ret_ready/ret_count out, rd_* ARF reads, flush_o/flush_pc, instret.
module arch_reg_commit #(
  parameter int RETIRE_WIDTH = 2,
  parameter int XLEN         = 32,
  parameter int NUM_AREGS    = 32,
  parameter int READ_PORTS   = 4,
  localparam int CW          = $clog2(RETIRE_WIDTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [RETIRE_WIDTH-1:0]        ret_valid,
  input  logic [RETIRE_WIDTH-1:0]        ret_wen,
  input  logic [RETIRE_WIDTH*5-1:0]      ret_rd,
  input  logic [RETIRE_WIDTH*XLEN-1:0]   ret_data,
  input  logic [RETIRE_WIDTH-1:0]        ret_exc,
  input  logic [RETIRE_WIDTH*XLEN-1:0]   ret_pc,
  output logic                           ret_ready,
  output logic [CW-1:0]                  ret_count,
  input  logic [READ_PORTS*5-1:0]        rd_addr,
  output logic [READ_PORTS*XLEN-1:0]     rd_data,
  output logic                           flush_o,
  output logic [XLEN-1:0]                flush_pc,
  output logic [63:0]                    instret
);

  typedef enum logic {
    RUN,
    FLUSH
  } state_t;

  state_t state;
  state_t state_n;

  logic [XLEN-1:0] arf [NUM_AREGS];

  logic [RETIRE_WIDTH-1:0] commit;
  logic [CW-1:0]           n_commit;
  logic                    exc_hit;
  logic [XLEN-1:0]         exc_pc;
  logic                    run_on;

  assign ret_ready = (state == RUN) && !rst;
  assign flush_o   = (state == FLUSH);

  // Walk slots oldest first; consumption stops at the first
  // invalid slot and right after an excepting one.
  always_comb begin
    commit    = '0;
    n_commit  = '0;
    ret_count = '0;
    exc_hit   = 1'b0;
    exc_pc    = '0;
    run_on    = ret_ready;
    for (int i = 0; i < RETIRE_WIDTH; i++) begin
      if (run_on && ret_valid[i]) begin
        ret_count = ret_count + CW'(1);
        if (ret_exc[i]) begin
          exc_hit = 1'b1;
          exc_pc  = ret_pc[i*XLEN +: XLEN];
        end else begin
          commit[i] = 1'b1;
          n_commit  = n_commit + CW'(1);
        end
      end
      run_on = run_on && ret_valid[i] && !ret_exc[i];
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      RUN:     if (exc_hit) state_n = FLUSH;
      FLUSH:   state_n = RUN;
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      flush_pc <= '0;
      instret  <= '0;
    end else begin
      state   <= state_n;
      instret <= instret + 64'(n_commit);
      if (exc_hit) flush_pc <= exc_pc;
    end
  end

  // Slots are scanned in ascending order so the youngest
  // writer of a register lands last and wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_AREGS; r++) arf[r] <= '0;
    end else begin
      for (int r = 1; r < NUM_AREGS; r++) begin
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
          if (commit[i] && ret_wen[i] &&
              ret_rd[i*5 +: 5] == 5'(r))
            arf[r] <= ret_data[i*XLEN +: XLEN];
        end
      end
    end
  end

  // x0 and out-of-range indices fall through to zero.
  always_comb begin
    rd_data = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      for (int r = 1; r < NUM_AREGS; r++) begin
        if (rd_addr[p*5 +: 5] == 5'(r))
          rd_data[p*XLEN +: XLEN] = arf[r];
      end
    end
  end

endmodule

// File: tb/tb_arch_reg_commit.sv
// Testbench for arch_reg_commit: directed steps plus random traffic.
// Checks every cycle against a slot-walking reference model.
module tb_arch_reg_commit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ret_valid;
  logic [1:0]  ret_wen;
  logic [9:0]  ret_rd;
  logic [63:0] ret_data;
  logic [1:0]  ret_exc;
  logic [63:0] ret_pc;
  logic        ret_ready;
  logic [1:0]  ret_count;
  logic [19:0] rd_addr;
  logic [127:0] rd_data;
  logic        flush_o;
  logic [31:0] flush_pc;
  logic [63:0] instret;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_arf [32];
  logic [63:0] m_instret;
  logic        m_flush;
  logic [31:0] m_flush_pc;

  always #5 clk = ~clk;

  arch_reg_commit dut (
    .clk(clk), .rst(rst),
    .ret_valid(ret_valid), .ret_wen(ret_wen),
    .ret_rd(ret_rd), .ret_data(ret_data),
    .ret_exc(ret_exc), .ret_pc(ret_pc),
    .ret_ready(ret_ready), .ret_count(ret_count),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .flush_o(flush_o), .flush_pc(flush_pc),
    .instret(instret)
  );

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_slots();
    ret_valid = '0; ret_wen = '0; ret_rd = '0;
    ret_data = '0; ret_exc = '0; ret_pc = '0;
  endtask

  task automatic set_slot(int i, bit wen, logic [4:0] rd,
                          logic [31:0] d, bit exc, logic [31:0] pc);
    ret_valid[i] = 1'b1;
    ret_wen[i]   = wen;
    ret_rd[i*5 +: 5]    = rd;
    ret_data[i*32 +: 32] = d;
    ret_exc[i]   = exc;
    ret_pc[i*32 +: 32]   = pc;
  endtask

  task automatic chk_reads(string tag);
    for (int p = 0; p < 4; p++) begin
      logic [4:0] a;
      a = rd_addr[p*5 +: 5];
      chk($sformatf("%s_rd%0d_x%0d", tag, p, a),
          64'(rd_data[p*32 +: 32]), 64'(m_arf[a]));
    end
  endtask

  // Applies the current inputs for one clock and checks both the
  // combinational outputs before the edge and the state after it.
  task automatic do_cycle(string tag);
    bit ready_e;
    int cnt_e;
    bit stop;
    #1;
    ready_e = !rst && !m_flush;
    cnt_e = 0;
    stop = !ready_e;
    for (int i = 0; i < 2; i++) begin
      if (!stop && ret_valid[i]) begin
        cnt_e++;
        if (ret_exc[i]) stop = 1;
      end else begin
        stop = 1;
      end
    end
    chk({tag, "_ready"}, 64'(ret_ready), 64'(ready_e));
    chk({tag, "_count"}, 64'(ret_count), 64'(cnt_e));
    chk_reads({tag, "_pre"});
    if (rst) begin
      foreach (m_arf[r]) m_arf[r] = '0;
      m_instret = '0;
      m_flush = 0;
      m_flush_pc = '0;
    end else begin
      bit exc_seen = 0;
      for (int i = 0; i < cnt_e; i++) begin
        if (ret_exc[i]) begin
          exc_seen = 1;
          m_flush_pc = ret_pc[i*32 +: 32];
        end else begin
          m_instret = m_instret + 1;
          if (ret_wen[i] && ret_rd[i*5 +: 5] != 0)
            m_arf[ret_rd[i*5 +: 5]] = ret_data[i*32 +: 32];
        end
      end
      m_flush = exc_seen;
    end
    @(posedge clk);
    #1;
    chk({tag, "_flush"}, 64'(flush_o), 64'(m_flush));
    chk({tag, "_fpc"}, 64'(flush_pc), 64'(m_flush_pc));
    chk({tag, "_instret"}, instret, m_instret);
    chk_reads({tag, "_post"});
  endtask

  initial begin
    foreach (m_arf[r]) m_arf[r] = '0;
    m_instret = '0;
    m_flush = 0;
    m_flush_pc = '0;
    rst = 1'b1;
    clear_slots();
    rd_addr = {5'd0, 5'd3, 5'd7, 5'd5};
    @(posedge clk);
    #1;
    do_cycle("reset");

    rst = 1'b0;
    set_slot(0, 1, 5'd5, 32'hDEAD, 0, 32'h0);
    do_cycle("t1");
    chk("t1_x5_const", 64'(rd_data[31:0]), 64'h0000DEAD);
    chk("t1_instret_const", instret, 64'd1);

    clear_slots();
    set_slot(0, 1, 5'd7, 32'h11, 0, 32'h0);
    set_slot(1, 1, 5'd7, 32'h22, 0, 32'h0);
    do_cycle("t2");
    chk("t2_x7_const", 64'(rd_data[63:32]), 64'h22);
    chk("t2_instret_const", instret, 64'd3);

    clear_slots();
    set_slot(0, 1, 5'd3, 32'h55, 1, 32'h100);
    set_slot(1, 1, 5'd3, 32'h66, 0, 32'h0);
    do_cycle("t3");
    chk("t3_flush_const", 64'(flush_o), 64'd1);
    chk("t3_fpc_const", 64'(flush_pc), 64'h100);
    do_cycle("t3_flushcyc");
    chk("t3_ready_back", 64'(ret_ready), 64'd1);

    clear_slots();
    set_slot(0, 1, 5'd3, 32'h33, 0, 32'h0);
    set_slot(1, 1, 5'd9, 32'h99, 1, 32'h204);
    do_cycle("t4");
    chk("t4_x3_const", 64'(rd_data[95:64]), 64'h33);
    chk("t4_fpc_const", 64'(flush_pc), 64'h204);
    clear_slots();
    do_cycle("t4_flushcyc");

    set_slot(0, 1, 5'd0, 32'hFFFF, 0, 32'h0);
    do_cycle("t5a");
    chk("t5_x0_const", 64'(rd_data[127:96]), 64'd0);
    clear_slots();
    set_slot(1, 1, 5'd3, 32'hBAD, 0, 32'h0);
    ret_valid = 2'b10;
    do_cycle("t5b");
    chk("t5_x3_kept", 64'(rd_data[95:64]), 64'h33);

    clear_slots();
    set_slot(0, 1, 5'd4, 32'h44, 1, 32'h300);
    rst = 1'b1;
    do_cycle("t6");
    chk("t6_flush_const", 64'(flush_o), 64'd0);
    chk("t6_instret_const", instret, 64'd0);
    rst = 1'b0;
    clear_slots();
    for (int r = 0; r < 32; r += 4) begin
      rd_addr = {5'(r + 3), 5'(r + 2), 5'(r + 1), 5'(r)};
      do_cycle("t6_zero");
    end

    for (int n = 0; n < 400; n++) begin
      clear_slots();
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 3) != 0)
          set_slot(i, 1'($urandom), 5'($urandom), $urandom,
                   $urandom_range(0, 7) == 0, $urandom);
      end
      rd_addr = 20'($urandom);
      rst = ($urandom_range(0, 49) == 0);
      do_cycle("rand");
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
